// File: rtl/axi_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_master
// Description : Emits one AXI-Stream style packet per accepted request. A
//               request (start with a non-zero len) produces len beats whose
//               payloads count up from first_data, wrapping modulo 2^DATA_W.
//               The final beat is flagged with last, and a single-cycle done
//               pulse follows it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W     : stream payload width in bits
//   LEN_W      : packet length field width in bits
// Ports
//   clk        : in  - clock, all logic on the rising edge
//   reset_n    : in  - asynchronous active-low reset
//   start      : in  - packet request, honoured only in IDLE
//   len        : in  - packet length in beats, sampled with start (0 ignored)
//   first_data : in  - payload of beat 0, sampled with start
//   data       : out - stream payload (registered)
//   valid      : out - beat on data is offered (registered)
//   last       : out - final beat of the packet (registered)
//   ready      : in  - receiver accepts the current beat
//   busy       : out - high whenever the block is not in IDLE
//   done       : out - one-cycle pulse after the last beat transfers
// ============================================================================
module axi_stream_master #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] first_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0]  c_LEN_ZERO = '0;
  localparam logic [LEN_W-1:0]  c_LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  c_LEN_TWO  = LEN_W'(2);
  localparam logic [DATA_W-1:0] c_DATA_ONE = DATA_W'(1);

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_done;
  logic [LEN_W-1:0]  r_cnt;    // beats still to transfer, including the one on the bus

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_valid_nxt;
  logic              w_last_nxt;
  logic              w_done_nxt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic              w_accept;

  // A beat moves only when both sides agree on the same edge.
  assign w_accept = r_valid & ready;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Default: hold everything (this is also the SEND stall behaviour);
    // done is a pulse so it defaults low.
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      IDLE: begin
        // A zero-length request carries no beats and is dropped silently.
        if (start && (len != c_LEN_ZERO)) begin
          w_cnt_nxt   = len;
          w_data_nxt  = first_data;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (len == c_LEN_ONE);
          w_state_nxt = SEND;
        end
      end

      SEND: begin
        if (w_accept) begin
          if (r_last) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_data_nxt  = '0;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_data_nxt  = r_data + c_DATA_ONE;
            w_cnt_nxt   = r_cnt - c_LEN_ONE;
            // Two remaining now means exactly one remains after this beat.
            w_last_nxt  = (r_cnt == c_LEN_TWO);
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign last  = r_last;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_master
// Description : Directed self-checking bench for axi_stream_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_master;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] len;
  logic [7:0] first_data;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int hs       = 0;   // handshakes seen on rising edges

  axi_stream_master #(.DATA_W(8), .LEN_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .len        (len),
    .first_data (first_data),
    .data       (data),
    .valid      (valid),
    .last       (last),
    .ready      (ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) hs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks all outputs at once: valid, last, data, done, busy.
  task automatic chk_out(input string tag, input logic v, input logic l,
                         input logic [7:0] d, input logic dn, input logic b);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, ".last"},  {31'd0, last},  {31'd0, l});
    chk({tag, ".data"},  {24'd0, data},  {24'd0, d});
    chk({tag, ".done"},  {31'd0, done},  {31'd0, dn});
    chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int hs0;

  initial begin
    reset_n = 1'b1; start = 1'b0; len = 8'd0; first_data = 8'd0; ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_out("reset_async", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick; tick;
    chk_out("reset_held", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;

    // ---------------- Basic packet: len=4 from 0x10 ----------------
    start = 1'b1; len = 8'd4; first_data = 8'h10; ready = 1'b1;
    hs0 = hs;
    tick; start = 1'b0;
    chk_out("basic_b0", 1'b1, 1'b0, 8'h10, 1'b0, 1'b1);
    tick; chk_out("basic_b1", 1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    tick; chk_out("basic_b2", 1'b1, 1'b0, 8'h12, 1'b0, 1'b1);
    tick; chk_out("basic_b3", 1'b1, 1'b1, 8'h13, 1'b0, 1'b1);
    tick; chk_out("basic_done", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick; chk_out("basic_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("basic_hs", hs - hs0, 32'd4);

    // ---------------- Backpressure: len=3 from 0xA0 ----------------
    start = 1'b1; len = 8'd3; first_data = 8'hA0; ready = 1'b0;
    hs0 = hs;
    tick; start = 1'b0;
    chk_out("bp_b0", 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1);
    tick; chk_out("bp_stall1", 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1);
    tick; chk_out("bp_stall2", 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1);
    ready = 1'b1;
    tick; chk_out("bp_b1", 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
    tick; chk_out("bp_b2", 1'b1, 1'b1, 8'hA2, 1'b0, 1'b1);
    tick; chk_out("bp_done", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick; chk_out("bp_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("bp_hs", hs - hs0, 32'd3);

    // ---------------- Wrap: len=3 from 0xFE ----------------
    start = 1'b1; len = 8'd3; first_data = 8'hFE;
    tick; start = 1'b0;
    chk_out("wrap_b0", 1'b1, 1'b0, 8'hFE, 1'b0, 1'b1);
    tick; chk_out("wrap_b1", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
    tick; chk_out("wrap_b2", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    tick; chk_out("wrap_done", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick; chk_out("wrap_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // ---------------- Single beat: len=1 from 0x55 ----------------
    start = 1'b1; len = 8'd1; first_data = 8'h55;
    hs0 = hs;
    tick; start = 1'b0;
    chk_out("single_b0", 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    tick; chk_out("single_done", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick; chk_out("single_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("single_hs", hs - hs0, 32'd1);

    // ---------------- Ignored: len=0 ----------------
    start = 1'b1; len = 8'd0; first_data = 8'h77;
    tick; chk_out("len0_a", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick; chk_out("len0_b", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    start = 1'b0;

    // ---------------- Ignored: start mid-packet and during DONE ----------------
    start = 1'b1; len = 8'd3; first_data = 8'h20;
    tick;
    chk_out("mid_b0", 1'b1, 1'b0, 8'h20, 1'b0, 1'b1);
    len = 8'd5; first_data = 8'h90;          // start stays high
    tick; chk_out("mid_b1", 1'b1, 1'b0, 8'h21, 1'b0, 1'b1);
    tick; chk_out("mid_b2", 1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
    tick; chk_out("mid_done", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick; chk_out("mid_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    start = 1'b0;
    tick; chk_out("mid_noqueue", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // ---------------- Reset mid-packet ----------------
    start = 1'b1; len = 8'd8; first_data = 8'h40;
    tick; start = 1'b0;
    chk_out("rst_b0", 1'b1, 1'b0, 8'h40, 1'b0, 1'b1);
    tick; tick; tick;
    chk_out("rst_b3", 1'b1, 1'b0, 8'h43, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    chk_out("rst_hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    start = 1'b1; len = 8'd2; first_data = 8'h30;
    tick; start = 1'b0;
    chk_out("post_b0", 1'b1, 1'b0, 8'h30, 1'b0, 1'b1);
    tick; chk_out("post_b1", 1'b1, 1'b1, 8'h31, 1'b0, 1'b1);
    tick; chk_out("post_done", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick; chk_out("post_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // ---------------- Maximum length: len=255 from 0x00 ----------------
    start = 1'b1; len = 8'd255; first_data = 8'h00;
    hs0 = hs;
    tick; start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      chk("max_valid", {31'd0, valid}, 32'd1);
      chk("max_data",  {24'd0, data},  i);
      chk("max_last",  {31'd0, last},  (i == 254) ? 32'd1 : 32'd0);
      tick;
    end
    chk_out("max_done", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick; chk_out("max_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("max_hs", hs - hs0, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_stream_master.md
AXI_STREAM_MASTER -- requirements
Module: axi_stream_master

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the stream data width in bits.
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the packet-length field width in bits.
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be rising-edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: packet request, sampled on the rising clock edge.
REQ-006 Port len, input, LEN_W: packet length in beats, sampled with start.
REQ-007 Port first_data, input, DATA_W: payload of beat 0, sampled with start.
REQ-008 Port data, output reg, DATA_W: stream payload.
REQ-009 Port valid, output reg, 1: the beat on data is offered.
REQ-010 Port last, output reg, 1: marks the final beat of the packet.
REQ-011 Port ready, input, 1: the receiver accepts the beat.
REQ-012 Port busy, output, 1: high in any state except IDLE.
REQ-013 Port done, output reg, 1: one-cycle completion pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, SEND and DONE.
REQ-015 Handshake SHALL be valid & ready; a beat transfers only on a clock edge where both are high.
REQ-016 IDLE: on start=1 with len!=0:
  - latch len into a remaining-beat counter;
  - load data <= first_data, valid <= 1, last <= (len==1);
  - go to SEND.
  The first beat is therefore visible the cycle after start.
REQ-017 IDLE: start=1 with len==0 SHALL be ignored; state stays IDLE, no valid, no done.
REQ-018 start SHALL be ignored in SEND and DONE; it is not queued.
REQ-019 SEND with no handshake: data, valid and last SHALL hold their values unchanged (stall).
REQ-020 SEND, handshake on a non-last beat, all on the next edge:
  - data <= data + 1, modulo 2^DATA_W (0xFF wraps to 0x00 for DATA_W=8);
  - decrement the remaining-beat counter;
  - last <= 1 when exactly one beat remains after this transfer.
REQ-021 SEND, handshake with last=1, on the next edge:
  - valid <= 0, last <= 0, data <= 0;
  - done <= 1;
  - go to DONE.
REQ-022 DONE SHALL last exactly one cycle, with done=1 and valid=0, then return to IDLE with done <= 0.
REQ-023 valid SHALL never depend combinationally on ready; once asserted, valid SHALL stay high until its beat is accepted.
REQ-024 last SHALL be high only when valid is high, and on exactly one beat per packet.
REQ-025 A packet of N beats SHALL produce exactly N handshakes with payloads first_data, first_data+1, ..., first_data+N-1.
REQ-026 Throughput: with ready held at 1, a packet of N beats SHALL occupy N consecutive valid cycles, followed by one DONE cycle.
REQ-027 The minimum start-to-start spacing SHALL be N+2 cycles: start cycle, N beats, DONE.
REQ-028 The remaining-beat counter SHALL be LEN_W bits wide; len = 2^LEN_W-1 SHALL be fully supported.

Reset
REQ-029 While reset_n=0, the block SHALL force:
  - state = IDLE;
  - data = 0, valid = 0, last = 0, done = 0, busy = 0;
  - beat counter = 0.
REQ-030 Reset SHALL act immediately and asynchronously, including in the middle of a packet; the abandoned packet is not resumed.
REQ-031 After reset_n rises, the first start SHALL be honoured on the first rising edge.

Verification
REQ-032 The bench SHALL cover at least these directed scenarios:
  - Basic packet: start, len=4, first_data=0x10, ready=1 -> beats 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles; last only on 0x13; done pulse the next cycle; busy low one cycle later.
  - Backpressure: len=3, first_data=0xA0, ready low for 2 cycles after the first valid -> data held at 0xA0 with valid=1 during the stall; then 0xA1 and 0xA2 (last); exactly 3 handshakes.
  - Wrap and single beat: len=3, first_data=0xFE -> 0xFE, 0xFF, 0x00 (last). Then len=1, first_data=0x55 -> one beat 0x55 with last=1 on the first valid cycle.
  - Ignored requests: start with len=0 in IDLE -> no valid, no done, busy stays 0. Start asserted mid-packet and during DONE -> no effect on the current packet, and no packet follows.
  - Reset mid-packet: len=8 and reset_n low after 3 handshakes -> valid, last, data and done go to 0 without waiting for a clock edge. After release, start with len=2, first_data=0x30 -> clean 0x30, 0x31 packet.
  - Maximum length: len=255, first_data=0x00, ready=1 -> 255 beats ending at 0xFE with last=1, then done.
